fir_gpio_reporter: RTL and testbench

FIR_GPIO_REPORTER -- requirements
Module: fir_gpio_reporter

---
 rtl/fir_gpio_reporter_if.sv | 26 ++
 rtl/fir_gpio_reporter.sv | 189 ++++++++++++++++++
 tb/tb_fir_gpio_reporter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_gpio_reporter_if.sv
// Streaming handshake bundle between the FIR output stage and the GPIO reporter.
//   ss_tvalid : upstream beat valid
//   ss_tdata  : 32-bit two's-complement FIR result
//   ss_tlast  : final result of a run
//   ss_tready : reporter can accept a beat this cycle
// master = FIR side (drives the beat), slave = reporter side (drives ss_tready).
interface fir_gpio_reporter_if;
  logic        ss_tvalid;
  logic [31:0] ss_tdata;
  logic        ss_tlast;
  logic        ss_tready;

  modport master (
    output ss_tvalid,
    output ss_tdata,
    output ss_tlast,
    input  ss_tready
  );

  modport slave (
    input  ss_tvalid,
    input  ss_tdata,
    input  ss_tlast,
    output ss_tready
  );
endinterface

// File: rtl/fir_gpio_reporter.sv
// Reports a run of FIR results on user GPIO pins [31:16].
// A start pulse shows START_MARK, then each buffered result's low 16 bits, then END_MARK.
// Every pattern stays on the pins for hold_q cycles (hold_cycles latched at start, 0 -> 1).
// Ports:
//   axis_clk, axis_rst_n : clock, asynchronous active-low reset
//   ss                   : slave side of the result stream (fir_gpio_reporter_if)
//   start                : single-cycle pulse arming a run (honoured in IDLE/DONE only)
//   hold_cycles          : cycles per pattern
//   io_out, io_oeb       : GPIO pattern and output-enable bar (0 = drive)
//   busy, done           : run in progress / run finished
module fir_gpio_reporter #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [15:0] START_MARK = 16'hAB40,
  parameter logic [15:0] END_MARK   = 16'hAB51
) (
  input  logic                      axis_clk,
  input  logic                      axis_rst_n,
  fir_gpio_reporter_if.slave        ss,
  input  logic                      start,
  input  logic [15:0]               hold_cycles,
  output logic [15:0]               io_out,
  output logic [15:0]               io_oeb,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StMarkS, StStream, StMarkE, StDone} state_e;

  // FIFO of {tlast, tdata[15:0]}
  logic [16:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [16:0]     rd_entry;

  state_e      state_q;
  logic [15:0] hold_q;
  logic [15:0] cnt_q;        // remaining cycles of the current pattern minus one
  logic        hold_act_q;   // a FIFO entry is currently being held on io_out
  logic        cur_last_q;   // the held entry carried tlast
  logic        last_seen_q;  // tlast beat accepted this run; refuse further beats
  logic [15:0] io_out_q, io_oeb_q;
  logic        busy_q, done_q;

  logic        tready, push, pop, start_ok;
  logic [15:0] hold_eff;
  logic        unused_tdata_hi;

  assign unused_tdata_hi = ^ss.ss_tdata[31:16];

  assign hold_eff = (hold_cycles == 16'd0) ? 16'd1 : hold_cycles;
  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
  assign rd_entry = mem_q[rd_ptr_q];

  // Decoded only from registers, so it never follows ss_tvalid.
  assign tready = ((state_q == StMarkS) || (state_q == StStream)) &&
                  (count_q < DepthCnt) && !last_seen_q;
  assign ss.ss_tready = tready;
  assign push = ss.ss_tvalid && tready;

  // Pop whenever the display is free for a new entry: at the end of the start mark, at the
  // expiry of a non-last entry, or while starved with nothing held.
  always_comb begin
    pop = 1'b0;
    if (count_q != '0) begin
      if (state_q == StMarkS) begin
        pop = (cnt_q == 16'd0);
      end else if (state_q == StStream) begin
        pop = !hold_act_q || ((cnt_q == 16'd0) && !cur_last_q);
      end
    end
  end

  always_ff @(posedge axis_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {ss.ss_tlast, ss.ss_tdata[15:0]};
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (start_ok) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q     <= StIdle;
      hold_q      <= 16'd0;
      cnt_q       <= 16'd0;
      hold_act_q  <= 1'b0;
      cur_last_q  <= 1'b0;
      last_seen_q <= 1'b0;
      io_out_q    <= 16'h0000;
      io_oeb_q    <= 16'hFFFF;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (push && ss.ss_tlast) last_seen_q <= 1'b1;

      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StMarkS;
            hold_q      <= hold_eff;
            cnt_q       <= hold_eff - 16'd1;
            hold_act_q  <= 1'b0;
            cur_last_q  <= 1'b0;
            last_seen_q <= 1'b0;
            io_out_q    <= START_MARK;
            io_oeb_q    <= 16'h0000;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end

        StMarkS: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            state_q <= StStream;
            if (pop) begin
              io_out_q   <= rd_entry[15:0];
              cur_last_q <= rd_entry[16];
              cnt_q      <= hold_q - 16'd1;
              hold_act_q <= 1'b1;
            end else begin
              hold_act_q <= 1'b0;
            end
          end
        end

        StStream: begin
          if (hold_act_q && (cnt_q != 16'd0)) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (hold_act_q && cur_last_q) begin
            state_q    <= StMarkE;
            io_out_q   <= END_MARK;
            cnt_q      <= hold_q - 16'd1;
            hold_act_q <= 1'b0;
          end else if (pop) begin
            io_out_q   <= rd_entry[15:0];
            cur_last_q <= rd_entry[16];
            cnt_q      <= hold_q - 16'd1;
            hold_act_q <= 1'b1;
          end else begin
            // Starved: keep the last pattern and wait indefinitely.
            hold_act_q <= 1'b0;
          end
        end

        StMarkE: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign io_out = io_out_q;
  assign io_oeb = io_oeb_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fir_gpio_reporter.sv
// Randomized self-checking bench for fir_gpio_reporter. The reference model is the list of
// patterns a run must show (START, each result's low half, END) with the hold length of each;
// the observed io_out trace is compressed into (value, length) segments and compared.
module tb_fir_gpio_reporter;
  localparam logic [15:0] StartMark = 16'hAB40;
  localparam logic [15:0] EndMark   = 16'hAB51;
  localparam int Depth = 4;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] hold_cycles = 16'd0;
  logic [15:0] io_out, io_oeb;
  logic        busy, done;

  fir_gpio_reporter_if ss_if ();

  fir_gpio_reporter #(
    .DEPTH      (Depth),
    .START_MARK (StartMark),
    .END_MARK   (EndMark)
  ) u_dut (
    .axis_clk    (axis_clk),
    .axis_rst_n  (axis_rst_n),
    .ss          (ss_if),
    .start       (start),
    .hold_cycles (hold_cycles),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .busy        (busy),
    .done        (done)
  );

  always #5 axis_clk = ~axis_clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] beats [$];
  logic [15:0] trace [$];
  bit          busy_drop;
  bit          oeb_bad;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] rnd_beat(input logic [15:0] prev);
    logic [31:0] v;
    v = $urandom;
    while (v[15:0] == prev || v[15:0] == StartMark || v[15:0] == EndMark) v = $urandom;
    return v;
  endfunction

  task automatic fill_random(input int n);
    logic [15:0] prev;
    beats.delete();
    prev = StartMark;
    for (int i = 0; i < n; i++) begin
      beats.push_back(rnd_beat(prev));
      prev = beats[i][15:0];
    end
  endtask

  // Presents every beat in order; inserts an idle gap before beat gap_after.
  task automatic drive_beats(input int gap_after, input int gap_len, output int stall_at);
    int tmo;
    stall_at = -1;
    for (int i = 0; i < beats.size(); i++) begin
      if (i == gap_after && gap_len > 0) begin
        ss_if.ss_tvalid = 1'b0;
        repeat (gap_len) @(negedge axis_clk);
      end
      ss_if.ss_tvalid = 1'b1;
      ss_if.ss_tdata  = beats[i];
      ss_if.ss_tlast  = (i == beats.size() - 1);
      #1;
      tmo = 0;
      while (!ss_if.ss_tready && tmo < 2000) begin
        if (stall_at < 0) stall_at = i;
        @(negedge axis_clk);
        #1;
        tmo++;
      end
      if (tmo >= 2000) begin
        check_eq("tready_timeout", 32'(tmo), 32'd0);
        break;
      end
      @(negedge axis_clk);
    end
    ss_if.ss_tvalid = 1'b0;
    ss_if.ss_tlast  = 1'b0;
    #1;
    check_eq("tready_after_last", 32'(ss_if.ss_tready), 32'd0);
  endtask

  // Records io_out once per cycle until done; can fire one extra start pulse mid-run.
  task automatic monitor(input int extra_at);
    int cyc;
    trace.delete();
    busy_drop = 0;
    oeb_bad   = 0;
    cyc = 0;
    while (!done && cyc < 5000) begin
      trace.push_back(io_out);
      if (!busy) busy_drop = 1;
      if (io_oeb != 16'h0000) oeb_bad = 1;
      if (cyc == extra_at) begin
        start = 1'b1;
        hold_cycles = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge axis_clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 5000) check_eq("done_timeout", 32'(cyc), 32'd0);
  endtask

  // One reporting run over the current beats. Segment 'loose' may legitimately last longer
  // than the hold (waiting for data); every other segment must last exactly the hold.
  task automatic run(input int hold_in, input int loose, input int gap_after, input int gap_len,
                     input int extra_at, output int stall_at);
    int h, n, k;
    logic [15:0] vals [$];
    int          lens [$];
    logic [15:0] exp_v;
    n = beats.size();
    h = (hold_in == 0) ? 1 : hold_in;
    @(negedge axis_clk);
    hold_cycles = 16'(hold_in);
    start = 1'b1;
    @(negedge axis_clk);
    start = 1'b0;
    hold_cycles = 16'($urandom);  // must not affect the armed run
    fork
      monitor(extra_at);
      drive_beats(gap_after, gap_len, stall_at);
    join
    foreach (trace[i]) begin
      if (i == 0 || trace[i] != vals[vals.size() - 1]) begin
        vals.push_back(trace[i]);
        lens.push_back(1);
      end else begin
        lens[lens.size() - 1]++;
      end
    end
    check_eq("seg_count", 32'(vals.size()), 32'(n + 2));
    for (k = 0; k < n + 2 && k < vals.size(); k++) begin
      if (k == 0) exp_v = StartMark;
      else if (k == n + 1) exp_v = EndMark;
      else exp_v = beats[k - 1][15:0];
      check_eq("seg_val", 32'(vals[k]), 32'(exp_v));
      if (k == loose) check_eq("seg_len_min", 32'(lens[k] >= h), 32'd1);
      else check_eq("seg_len", 32'(lens[k]), 32'(h));
    end
    check_eq("busy_during_run", 32'(busy_drop), 32'd0);
    check_eq("oeb_during_run", 32'(oeb_bad), 32'd0);
    check_eq("done_io_out", 32'(io_out), 32'(EndMark));
    check_eq("done_busy", 32'(busy), 32'd0);
    check_eq("done_tready", 32'(ss_if.ss_tready), 32'd0);
    repeat (3) @(negedge axis_clk);
    check_eq("done_io_out_stays", 32'(io_out), 32'(EndMark));
    check_eq("done_oeb", 32'(io_oeb), 32'h0000);
    check_eq("done_flag", 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_io_out"}, 32'(io_out), 32'h0000);
    check_eq({tag, "_io_oeb"}, 32'(io_oeb), 32'hFFFF);
    check_eq({tag, "_tready"}, 32'(ss_if.ss_tready), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_at;
    ss_if.ss_tvalid = 1'b0;
    ss_if.ss_tdata  = 32'd0;
    ss_if.ss_tlast  = 1'b0;
    #3 axis_rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge axis_clk);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);
    check_reset_outputs("idle");

    // Nominal run with the documented FIR output sequence.
    beats = '{32'd0, -32'sd10, -32'sd29, -32'sd25, 32'd35, 32'd158, 32'd337, 32'd539,
              32'd732, 32'd915, 32'd1098};
    run(3, -1, -1, 0, -1, stall_at);

    // Backpressure: long hold, 8 beats presented back to back.
    fill_random(8);
    run(10, -1, -1, 0, -1, stall_at);
    check_eq("first_stall_index", 32'(stall_at), 32'(Depth));

    // Starvation: 50 idle cycles after four beats; that fourth value is held over the gap.
    fill_random(8);
    run(3, 4, 4, 50, -1, stall_at);

    // hold_cycles = 0 with an ignored start pulse mid-run.
    fill_random(5);
    run(0, 0, -1, 0, 3, stall_at);

    // Random continuous runs.
    for (int r = 0; r < 4; r++) begin
      fill_random(int'($urandom_range(3, 10)));
      run(int'($urandom_range(2, 5)), -1, -1, 0, -1, stall_at);
    end

    // Reset mid-STREAM with entries buffered, then a clean run.
    @(negedge axis_clk);
    hold_cycles = 16'd4;
    start = 1'b1;
    @(negedge axis_clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ss_if.ss_tvalid = 1'b1;
      ss_if.ss_tdata  = {16'h0, 4'h5, 12'($urandom)};
      ss_if.ss_tlast  = 1'b0;
      @(negedge axis_clk);
    end
    ss_if.ss_tvalid = 1'b0;
    check_eq("pre_reset_busy", 32'(busy), 32'd1);
    #2 axis_rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);
    check_reset_outputs("post_reset");
    fill_random(6);
    run(2, -1, -1, 0, -1, stall_at);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
